// File: rtl/bitlet_pkg.sv
// bitlet_pkg: shared constants, bank state encoding and width helpers for the Bitlet accumulator
package bitlet_pkg;
  localparam int N_CH_D   = 24;
  localparam int W_IN_D   = 8;
  localparam int W_ACC_D  = 32;
  localparam int N_BANK_D = 2;
  typedef enum logic [1:0] {B_FREE, B_FILL, B_DONE} bank_st_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int w_sum(input int n, input int w);
    return w + clog2(n);
  endfunction
endpackage

// File: rtl/bitlet_add_tree.sv
// bitlet_add_tree: pipelined signed reduction of N_CH channels, latency clog2(N_CH), with valid/tag/last sideband
// ports: clk, rst_n (async, active-low), flush (kills valids), in_vld/in_tag/in_last/in_vec in,
//        out_vld/out_tag/out_last/out_sum out (out_sum is W_IN+clog2(N_CH) bits signed)
module bitlet_add_tree
  import bitlet_pkg::*;
#(
  parameter int N_CH = N_CH_D,
  parameter int W_IN = W_IN_D,
  parameter int TW   = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush,
  input  logic                                 in_vld,
  input  logic [TW-1:0]                        in_tag,
  input  logic                                 in_last,
  input  logic [N_CH*W_IN-1:0]                 in_vec,
  output logic                                 out_vld,
  output logic [TW-1:0]                        out_tag,
  output logic                                 out_last,
  output logic signed [W_IN+clog2(N_CH)-1:0]   out_sum
);
  localparam int L     = clog2(N_CH);
  localparam int P     = 1 << L;
  localparam int W_SUM = W_IN + L;
  logic signed [W_SUM-1:0] leaf [P];
  // levels 1..L packed back to back: level g starts at P - (2P >> g), final node at P-2
  logic signed [W_SUM-1:0] node [P-1];
  logic [L-1:0] v_q, l_q;
  logic [TW-1:0] t_q [L];
  for (genvar k = 0; k < P; k++) begin : g_leaf
    if (k < N_CH) begin : g_ch
      assign leaf[k] = W_SUM'($signed(in_vec[k*W_IN +: W_IN]));
    end else begin : g_pad
      assign leaf[k] = '0;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < P / 2; i++) node[i] <= leaf[2*i] + leaf[2*i+1];
    for (int g = 2; g <= L; g++)
      for (int i = 0; i < (P >> g); i++)
        node[P - (2*P >> g) + i] <= node[P - (4*P >> g) + 2*i] + node[P - (4*P >> g) + 2*i + 1];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
    end else begin
      v_q[0] <= in_vld && !flush;
      for (int i = 1; i < L; i++) v_q[i] <= v_q[i-1] && !flush;
    end
  end
  always_ff @(posedge clk) begin
    t_q[0] <= in_tag;
    l_q[0] <= in_last;
    for (int i = 1; i < L; i++) begin
      t_q[i] <= t_q[i-1];
      l_q[i] <= l_q[i-1];
    end
  end
  assign out_vld  = v_q[L-1];
  assign out_tag  = t_q[L-1];
  assign out_last = l_q[L-1];
  assign out_sum  = node[P-2];
endmodule

// File: rtl/bitlet_acc_multi.sv
// bitlet_acc_multi: reduces N_CH-channel beats through an adder tree and accumulates bursts into N_BANK banks
// ports: clk, rst_n (async, active-low), flush (sync clear), in_vld/in_rdy/in_last/in_vec beat input,
//        out_vld/out_rdy/out_data/out_ovf result output
// BITLET_ACC_SAT_EN: saturating bank addition with sticky out_ovf; otherwise wrap-around and out_ovf = 0
module bitlet_acc_multi
  import bitlet_pkg::*;
#(
  parameter int N_CH   = N_CH_D,
  parameter int W_IN   = W_IN_D,
  parameter int W_ACC  = W_ACC_D,
  parameter int N_BANK = N_BANK_D
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic                 in_last,
  input  logic [N_CH*W_IN-1:0] in_vec,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [W_ACC-1:0]     out_data,
  output logic                 out_ovf
);
  localparam int TW    = clog2(N_BANK);
  localparam int W_SUM = w_sum(N_CH, W_IN);
  bank_st_e st [N_BANK], st_d [N_BANK];
  logic signed [W_ACC-1:0] bank [N_BANK], bank_d [N_BANK];
  logic [TW-1:0] wr_ptr, rd_ptr, wr_d, rd_d, t_tag;
  // open marks a burst in progress in bank[wr_ptr]; a FILL bank without it is closed and awaiting its last psum
  logic open, open_d, acc, hs, t_vld, t_last;
  logic signed [W_SUM-1:0] t_sum;
  logic signed [W_ACC-1:0] nxt;
  assign in_rdy   = st[wr_ptr] == B_FREE || open;
  assign acc      = in_vld && in_rdy && !flush;
  assign out_vld  = st[rd_ptr] == B_DONE;
  assign hs       = out_vld && out_rdy;
  assign out_data = bank[rd_ptr];
  bitlet_add_tree #(.N_CH(N_CH), .W_IN(W_IN), .TW(TW)) u_tree (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_vld(acc), .in_tag(wr_ptr), .in_last(in_last), .in_vec(in_vec),
    .out_vld(t_vld), .out_tag(t_tag), .out_last(t_last), .out_sum(t_sum)
  );
`ifdef BITLET_ACC_SAT_EN
  logic [W_ACC:0] sum;
  logic hit;
  logic ovf [N_BANK], ovf_d [N_BANK];
  assign sum = {bank[t_tag][W_ACC-1], bank[t_tag]} + (W_ACC+1)'(t_sum);
  assign hit = sum[W_ACC] ^ sum[W_ACC-1];
  assign nxt = hit ? {sum[W_ACC], {(W_ACC-1){~sum[W_ACC]}}} : sum[W_ACC-1:0];
  assign out_ovf = ovf[rd_ptr];
  always_comb begin
    ovf_d = ovf;
    for (int b = 0; b < N_BANK; b++) begin
      if (t_vld && t_tag == TW'(b) && hit) ovf_d[b] = 1'b1;
      if (hs && rd_ptr == TW'(b)) ovf_d[b] = 1'b0;
    end
    if (flush) ovf_d = '{default: 1'b0};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf <= '{default: 1'b0};
    else ovf <= ovf_d;
  end
`else
  assign nxt     = bank[t_tag] + W_ACC'(t_sum);
  assign out_ovf = 1'b0;
`endif
  always_comb begin
    st_d   = st;
    bank_d = bank;
    wr_d   = wr_ptr;
    rd_d   = rd_ptr;
    open_d = open;
    if (acc) begin
      open_d = !in_last;
      wr_d   = !in_last ? wr_ptr : wr_ptr == TW'(N_BANK-1) ? '0 : wr_ptr + 1'b1;
    end
    if (hs) rd_d = rd_ptr == TW'(N_BANK-1) ? '0 : rd_ptr + 1'b1;
    for (int b = 0; b < N_BANK; b++) begin
      if (acc && wr_ptr == TW'(b) && st[b] == B_FREE) st_d[b] = B_FILL;
      if (t_vld && t_tag == TW'(b)) begin
        bank_d[b] = nxt;
        st_d[b]   = t_last ? B_DONE : st[b];
      end
      if (hs && rd_ptr == TW'(b)) begin
        bank_d[b] = '0;
        st_d[b]   = B_FREE;
      end
    end
    if (flush) begin
      st_d   = '{default: B_FREE};
      bank_d = '{default: '0};
      wr_d   = '0;
      rd_d   = '0;
      open_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= '{default: B_FREE};
      bank   <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      open   <= 1'b0;
    end else begin
      st     <= st_d;
      bank   <= bank_d;
      wr_ptr <= wr_d;
      rd_ptr <= rd_d;
      open   <= open_d;
    end
  end
endmodule

// File: tb/tb_bitlet_acc_multi.sv
// tb_bitlet_acc_multi: directed table, corner sequences and random traffic against a burst-sum scoreboard
module tb_bitlet_acc_multi;
  localparam int N_CH = 24;
  localparam int W_IN = 8;
  localparam int N_BANK = 2;
  localparam int VW = N_CH * W_IN;
`ifdef BITLET_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_vld = 1'b0, in_last = 1'b0, out_rdy = 1'b0;
  logic [VW-1:0] in_vec = '0;
  logic in_rdy, out_vld, out_ovf, in_rdy16, out_vld16, out_ovf16;
  logic [31:0] out_data;
  logic [15:0] out_data16;
  int errors = 0, checks = 0;
  longint q[$], q16[$];
  bit qo16[$];
  longint acc32 = 0, acc16 = 0, bm = 0, s16 = 0;
  bit ovf16 = 1'b0;
  int closed = 0;
  logic signed [31:0] w32;
  logic signed [15:0] w16;

  bitlet_acc_multi dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_vld(in_vld), .in_rdy(in_rdy), .in_last(in_last),
    .in_vec(in_vec), .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_ovf(out_ovf)
  );
  bitlet_acc_multi #(.W_ACC(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_vld(in_vld), .in_rdy(in_rdy16), .in_last(in_last),
    .in_vec(in_vec), .out_vld(out_vld16), .out_rdy(out_rdy), .out_data(out_data16), .out_ovf(out_ovf16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] fill(input int v);
    logic [VW-1:0] r;
    for (int k = 0; k < N_CH; k++) r[k*W_IN +: W_IN] = W_IN'(v);
    return r;
  endfunction

  function automatic longint bsum(input logic [VW-1:0] v);
    longint s = 0;
    for (int k = 0; k < N_CH; k++) s += longint'($signed(v[k*W_IN +: W_IN]));
    return s;
  endfunction

  // scoreboard: a burst is the sum of its accepted beats; a bank is busy from its last beat until read out
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      q.delete(); q16.delete(); qo16.delete();
      acc32 = 0; acc16 = 0; ovf16 = 1'b0; closed = 0;
    end else begin
      chk("in_rdy", in_rdy, closed < N_BANK);
      if (out_vld && out_rdy) begin
        if (q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          chk("out_data", $signed(out_data), q.pop_front());
          chk("out_ovf", out_ovf, 0);
        end
        closed--;
      end
      if (out_vld16 && out_rdy) begin
        if (q16.size() == 0) chk("spurious_out16", 1, 0);
        else begin
          chk("out_data16", $signed(out_data16), q16.pop_front());
          chk("out_ovf16", out_ovf16, qo16.pop_front());
        end
      end
      if (in_vld && in_rdy) begin
        bm = bsum(in_vec);
        acc32 += bm;
        s16 = acc16 + bm;
        if (SAT && s16 > 32767) begin s16 = 32767; ovf16 = 1'b1; end
        if (SAT && s16 < -32768) begin s16 = -32768; ovf16 = 1'b1; end
        w16 = s16[15:0];
        acc16 = w16;
        if (in_last) begin
          w32 = acc32[31:0];
          q.push_back(w32);
          q16.push_back(acc16);
          qo16.push_back(ovf16);
          acc32 = 0; acc16 = 0; ovf16 = 1'b0;
          closed++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [VW-1:0] v, input bit last);
    int n = 0;
    bit took;
    in_vld = 1'b1; in_vec = v; in_last = last;
    do begin
      took = in_rdy;
      step();
      n++;
    end while (!took && n < 50);
    if (!took) chk("send_timeout", 0, 1);
    in_vld = 1'b0; in_last = 1'b0;
  endtask

  task automatic burst(input int beats, input int val);
    for (int i = 0; i < beats; i++) send(fill(val), i == beats - 1);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_vld && n < 40) begin
      step();
      n++;
    end
    if (!out_vld) chk("out_timeout", 0, 1);
  endtask

  task automatic quiet(input string name, input int cyc);
    bit seen = 1'b0;
    repeat (cyc) begin
      step();
      seen |= out_vld;
    end
    chk(name, seen, 0);
  endtask

  typedef struct { int beats; int val; longint exp; } vec_t;
  vec_t tv[6];

  initial begin
    int n;
    longint d;
    tv = '{'{3, 1, 72}, '{1, -128, -3072}, '{1, 2, 48}, '{2, -1, -48}, '{4, 127, 12192}, '{5, -128, -15360}};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ovf", out_ovf, 0);
    rst_n = 1'b1;
    step();
    out_rdy = 1'b1;
    foreach (tv[i]) begin
      burst(tv[i].beats, tv[i].val);
      wait_out(n);
      chk("latency", n + 1, 6);
      chk("tbl_data", $signed(out_data), tv[i].exp);
      chk("tbl_ovf", out_ovf, 0);
      step();
      chk("tbl_vld_drop", out_vld, 0);
    end
    // backpressure: two banks fill, third burst waits for a handshake
    out_rdy = 1'b0;
    burst(2, 3);
    burst(2, 4);
    chk("bp_rdy_low", in_rdy, 0);
    in_vld = 1'b1; in_vec = fill(5); in_last = 1'b0;
    repeat (8) step();
    chk("bp_rdy_still_low", in_rdy, 0);
    wait_out(n);
    d = $signed(out_data);
    repeat (3) step();
    chk("bp_hold_vld", out_vld, 1);
    chk("bp_hold_data", $signed(out_data), d);
    chk("bp_first", d, 144);
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    chk("bp_readmit", in_rdy, 1);
    step();
    send(fill(5), 1'b1);
    out_rdy = 1'b1;
    wait_out(n);
    chk("bp_second", $signed(out_data), 192);
    step();
    wait_out(n);
    chk("bp_third", $signed(out_data), 240);
    step();
    // flush mid-burst drops the partial burst and the beat presented with it
    send(fill(5), 1'b0);
    send(fill(5), 1'b0);
    in_vld = 1'b1; in_vec = fill(9); flush = 1'b1;
    step();
    flush = 1'b0; in_vld = 1'b0;
    chk("flush_vld", out_vld, 0);
    chk("flush_rdy", in_rdy, 1);
    burst(1, 2);
    wait_out(n);
    chk("flush_data", $signed(out_data), 48);
    step();
    quiet("flush_extra", 10);
    // 16-bit accumulator overflow
    burst(11, 127);
    wait_out(n);
    chk("ovf_wide", $signed(out_data), 33528);
    chk("ovf_data16", $signed(out_data16), SAT ? 32767 : -32008);
    chk("ovf_flag16", out_ovf16, SAT);
    step();
    // async reset mid-burst
    send(fill(1), 1'b0);
    send(fill(1), 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst1_rdy", in_rdy, 1);
    chk("rst1_vld", out_vld, 0);
    chk("rst1_data", out_data, 0);
    step();
    rst_n = 1'b1;
    quiet("rst1_partial", 10);
    // async reset while results are stalled
    out_rdy = 1'b0;
    burst(1, 7);
    burst(1, 8);
    wait_out(n);
    rst_n = 1'b0;
    #1;
    chk("rst2_rdy", in_rdy, 1);
    chk("rst2_vld", out_vld, 0);
    chk("rst2_data", out_data, 0);
    chk("rst2_ovf", out_ovf, 0);
    step();
    rst_n = 1'b1;
    quiet("rst2_partial", 10);
    out_rdy = 1'b1;
    burst(3, 1);
    wait_out(n);
    chk("rst2_next", $signed(out_data), 72);
    step();
    // random traffic against the scoreboard
    repeat (600) begin
      in_vld = ($urandom % 4) != 0;
      for (int k = 0; k < N_CH; k++) in_vec[k*W_IN +: W_IN] = W_IN'($urandom);
      in_last = ($urandom % 3) == 0;
      out_rdy = ($urandom % 3) != 0;
      flush = ($urandom % 50) == 0;
      step();
    end
    in_vld = 1'b0; in_last = 1'b0; flush = 1'b0; out_rdy = 1'b1;
    repeat (20) step();
    chk("drain", q.size(), 0);
    chk("drain16", q16.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
